// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter that serialises per-Core memory requests onto the
// single shared data-memory port. Each granted access runs IDLE -> BUSY ->
// RELEASE, so a finished Core's stale enable can never win a second grant.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no access in flight; scan requests from last+1 and grant one
// S_BUSY    | latched access driven to memory; wait for mem_ready/timeout
// S_RELEASE | one cycle after completion; core_ready pulse is dropped here
module core_mem_arbiter #(
  parameter int CORES   = 4,
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [2*CORES-1:0]         core_enable_i,
  input  logic [ADDR_W*CORES-1:0]    core_addr_i,
  input  logic [REG_W*CORES-1:0]     core_wr_data_i,
  output logic [REG_W-1:0]           core_rd_data_o,
  output logic [CORES-1:0]           core_ready_o,
  output logic [1:0]                 mem_enable_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [REG_W-1:0]           mem_wr_data_o,
  input  logic [REG_W-1:0]           mem_rd_data_i,
  input  logic                       mem_ready_i,
  output logic [$clog2(CORES)-1:0]   grant_id_o,
  output logic                       busy_o,
  output logic                       timeout_err_o
);

  localparam int GW = $clog2(CORES);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the last BUSY cycle before the timeout fires.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [1:0]          mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [REG_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [REG_W-1:0]    rd_data_q, rd_data_d;
  logic [CORES-1:0]    ready_q, ready_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                to_err_q, to_err_d;

  logic [1:0]          en_a    [CORES];
  logic [ADDR_W-1:0]   addr_a  [CORES];
  logic [REG_W-1:0]    wdata_a [CORES];
  logic [CORES-1:0]    valid;

  logic                req_found;
  logic [GW-1:0]       req_idx;
  logic [GW-1:0]       cand;

  // Unpack the flat per-Core buses; only 01 (read) and 10 (write) are requests.
  always_comb begin
    valid = '0;
    for (int i = 0; i < CORES; i++) begin
      en_a[i]    = core_enable_i[2*i +: 2];
      addr_a[i]  = core_addr_i[ADDR_W*i +: ADDR_W];
      wdata_a[i] = core_wr_data_i[REG_W*i +: REG_W];
      valid[i]   = ^core_enable_i[2*i +: 2];
    end
  end

  // Round-robin pick: first valid request scanning last+1, last+2, ... mod CORES.
  always_comb begin
    req_found = 1'b0;
    req_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= CORES; k++) begin
      cand = GW'((int'(last_q) + k) % CORES);
      if (!req_found && valid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Next-state and output-register logic for the grant/serve/release cycle.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    ready_d     = ready_q;
    cnt_d       = cnt_q;
    to_err_d    = to_err_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d = '0;
        if (req_found) begin
          grant_d     = req_idx;
          last_d      = req_idx;
          mem_en_d    = en_a[req_idx];
          mem_addr_d  = addr_a[req_idx];
          mem_wdata_d = wdata_a[req_idx];
          cnt_d       = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready_i) begin
          ready_d          = '0;
          ready_d[grant_q] = 1'b1;
          if (mem_en_q == 2'b01) begin
            rd_data_d = mem_rd_data_i;
          end
          mem_en_d = 2'b00;
          cnt_d    = '0;
          state_d  = S_RELEASE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          // Abandon the access but still release the Core so it cannot hang.
          ready_d          = '0;
          ready_d[grant_q] = 1'b1;
          rd_data_d        = '0;
          to_err_d         = 1'b1;
          mem_en_d         = 2'b00;
          cnt_d            = '0;
          state_d          = S_RELEASE;
        end
      end

      S_RELEASE: begin
        ready_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        ready_d  = '0;
        mem_en_d = 2'b00;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset points the pointer at the last Core
  // so Core 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      last_q      <= GW'(CORES - 1);
      grant_q     <= '0;
      mem_en_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      ready_q     <= '0;
      cnt_q       <= '0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      to_err_q    <= to_err_d;
    end
  end

  assign core_rd_data_o = rd_data_q;
  assign core_ready_o   = ready_q;
  assign mem_enable_o   = mem_en_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wr_data_o  = mem_wdata_q;
  assign grant_id_o     = grant_q;
  assign busy_o         = (state_q != S_IDLE);
  assign timeout_err_o  = to_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios followed by randomized
// request rounds, all checked against a transaction-level model that tracks
// pending requests, the round-robin pointer, read data and the sticky error.
module tb_core_mem_arbiter;

  localparam int CORES   = 4;
  localparam int REG_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [2*CORES-1:0]        core_enable;
  logic [ADDR_W*CORES-1:0]   core_addr;
  logic [REG_W*CORES-1:0]    core_wr_data;
  logic [REG_W-1:0]          core_rd_data;
  logic [CORES-1:0]          core_ready;
  logic [1:0]                mem_enable;
  logic [ADDR_W-1:0]         mem_addr;
  logic [REG_W-1:0]          mem_wr_data;
  logic [REG_W-1:0]          mem_rd_data;
  logic                      mem_ready;
  logic [$clog2(CORES)-1:0]  grant_id;
  logic                      busy;
  logic                      timeout_err;

  core_mem_arbiter #(
    .CORES(CORES), .REG_W(REG_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .core_enable_i(core_enable), .core_addr_i(core_addr), .core_wr_data_i(core_wr_data),
    .core_rd_data_o(core_rd_data), .core_ready_o(core_ready),
    .mem_enable_o(mem_enable), .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data), .mem_ready_i(mem_ready),
    .grant_id_o(grant_id), .busy_o(busy), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit         pend     [CORES];
  logic [1:0] op       [CORES];
  logic [7:0] c_addr   [CORES];
  logic [7:0] c_wdat   [CORES];
  logic [1:0] idle_pat [CORES];
  int         last;
  logic [7:0] exp_rd;
  logic       exp_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < CORES; i++) begin
      core_enable[2*i +: 2]       = pend[i] ? op[i] : idle_pat[i];
      core_addr[ADDR_W*i +: ADDR_W] = c_addr[i];
      core_wr_data[REG_W*i +: REG_W] = c_wdat[i];
    end
  endtask

  task automatic set_req(input int c, input logic [1:0] o, input logic [7:0] a, input logic [7:0] d);
    pend[c]   = 1'b1;
    op[c]     = o;
    c_addr[c] = a;
    c_wdat[c] = d;
    drive();
  endtask

  task automatic model_reset();
    last   = CORES - 1;
    exp_rd = 8'h00;
    exp_to = 1'b0;
    for (int i = 0; i < CORES; i++) pend[i] = 1'b0;
    drive();
  endtask

  function automatic bit any_pend();
    bit r;
    r = 1'b0;
    for (int i = 0; i < CORES; i++) r |= pend[i];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'd0);
    check({tag, "_core_ready"}, 32'(core_ready), 32'd0);
    check({tag, "_core_rd_data"}, 32'(core_rd_data), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on the negedge just after the grant edge. lat = BUSY cycle on
  // which memory answers; beyond TIMEOUT the access times out instead.
  task automatic serve_one(input int lat, input int add_core, input logic [7:0] rdat);
    int w, eff;
    bit to;
    logic [1:0] eo;
    logic [7:0] ea, ew;
    w = 0;
    for (int k = CORES; k >= 1; k--) if (pend[(last + k) % CORES]) w = (last + k) % CORES;
    last = w;
    eo = op[w];
    ea = c_addr[w];
    ew = c_wdat[w];
    check("grant_id", 32'(grant_id), 32'(w));
    check("grant_mem_enable", 32'(mem_enable), 32'(eo));
    check("grant_mem_addr", 32'(mem_addr), 32'(ea));
    check("grant_mem_wr_data", 32'(mem_wr_data), 32'(ew));
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_core_ready", 32'(core_ready), 32'd0);
    // Winner's inputs change mid-access; the latched values must not move.
    c_addr[w] = 8'($urandom);
    c_wdat[w] = 8'($urandom);
    if (add_core >= 0) begin
      pend[add_core]   = 1'b1;
      op[add_core]     = $urandom_range(0, 1) ? RD : WR;
      c_addr[add_core] = 8'($urandom);
      c_wdat[add_core] = 8'($urandom);
    end
    drive();
    to  = (lat > TIMEOUT);
    eff = to ? TIMEOUT : lat;
    for (int c = 1; c <= eff; c++) begin
      mem_ready   = (c == lat);
      mem_rd_data = (c == lat) ? rdat : 8'($urandom);
      @(negedge clk);
      if (c < eff) begin
        check("busy_mem_enable", 32'(mem_enable), 32'(eo));
        check("busy_mem_addr", 32'(mem_addr), 32'(ea));
        check("busy_core_ready", 32'(core_ready), 32'd0);
      end
    end
    mem_ready   = 1'($urandom_range(0, 1));
    mem_rd_data = 8'($urandom);
    if (to) begin
      exp_rd = 8'h00;
      exp_to = 1'b1;
    end else if (eo == RD) begin
      exp_rd = rdat;
    end
    check("done_core_ready", 32'(core_ready), 32'(1) << w);
    check("done_core_rd_data", 32'(core_rd_data), 32'(exp_rd));
    check("done_timeout_err", 32'(timeout_err), 32'(exp_to));
    check("done_mem_enable", 32'(mem_enable), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    pend[w] = 1'b0;
    drive();
    @(negedge clk);
    check("rel_core_ready", 32'(core_ready), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_core_rd_data", 32'(core_rd_data), 32'(exp_rd));
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    mem_ready   = 1'b0;
    mem_rd_data = 8'h00;
    for (int i = 0; i < CORES; i++) begin
      op[i] = 2'b00; c_addr[i] = 8'h00; c_wdat[i] = 8'h00; idle_pat[i] = 2'b00;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Core 1 reads 0x12, memory answers on the second BUSY cycle
    set_req(1, RD, 8'h12, 8'h00);
    @(negedge clk);
    serve_one(2, -1, 8'hA5);
    check("t1_rd_data", 32'(core_rd_data), 32'h0A5);

    // Core 2 writes 0x3C to 0x40; read data must stay 0xA5
    set_req(2, WR, 8'h40, 8'h3C);
    @(negedge clk);
    serve_one(1, -1, 8'h77);
    check("t2_rd_data_held", 32'(core_rd_data), 32'h0A5);

    // All four Cores from reset; Core 0 re-requests while Core 3 is served
    apply_reset();
    for (int c = 0; c < CORES; c++) set_req(c, RD, 8'(8'h20 + c), 8'h00);
    @(negedge clk); serve_one(1, -1, 8'h10);
    @(negedge clk); serve_one(2, -1, 8'h11);
    @(negedge clk); serve_one(1, -1, 8'h12);
    @(negedge clk); serve_one(3, 0, 8'h13);
    @(negedge clk); serve_one(1, -1, 8'h14);
    check("t3_last_grant_core0", 32'(grant_id), 32'd0);

    // last=0: Core 0 and Core 3 together -> 3 then 0
    set_req(0, RD, 8'h30, 8'h00);
    set_req(3, RD, 8'h33, 8'h00);
    @(negedge clk); serve_one(1, -1, 8'hC3);
    @(negedge clk); serve_one(2, -1, 8'hC0);

    // Timeout with mem_ready held low, then the flag must stay set
    set_req(1, RD, 8'h55, 8'h00);
    @(negedge clk); serve_one(TIMEOUT + 5, -1, 8'hEE);
    set_req(2, WR, 8'h56, 8'h9A);
    @(negedge clk); serve_one(1, -1, 8'h00);
    set_req(3, RD, 8'h57, 8'h00);
    @(negedge clk); serve_one(3, -1, 8'h5D);
    check("t5_err_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of BUSY; a late mem_ready must produce nothing
    set_req(2, RD, 8'h61, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    mem_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_no_ready", 32'(core_ready), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    for (int c = 0; c < CORES; c++) set_req(c, RD, 8'(8'h70 + c), 8'h00);
    @(negedge clk);
    check("t6_first_grant", 32'(grant_id), 32'd0);
    serve_one(1, -1, 8'h01);
    while (any_pend()) begin
      @(negedge clk);
      serve_one($urandom_range(1, 3), -1, 8'($urandom));
    end

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < CORES; i++) begin
        idle_pat[i] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
        if ($urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 1) ? RD : WR, 8'($urandom), 8'($urandom));
      end
      drive();
      while (any_pend()) begin
        int add, cidx;
        add  = -1;
        cidx = $urandom_range(0, CORES - 1);
        if (!pend[cidx] && $urandom_range(0, 3) == 0) add = cidx;
        @(negedge clk);
        serve_one($urandom_range(1, TIMEOUT + 2), add, 8'($urandom));
      end
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_mem_enable", 32'(mem_enable), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_core_ready", 32'(core_ready), 32'd0);
      check("idle_timeout_err", 32'(timeout_err), 32'(exp_to));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the single data-memory port between CORES Core instances.
- Each Core sees its own enable/addr/wr_data/ready memory interface; the arbiter serialises the accesses round-robin onto one memory-side port.
- Sits between the Core array and the shared data memory in the GPU top level.

Parameters:
- CORES, 4, number of requesting Cores (2..16).
- REG_W, 8, data width; matches the Core register width.
- ADDR_W, 8, memory address width.
- TIMEOUT, 64, max cycles to wait for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_enable  in  2*CORES  per-Core {wr,rd}: 2'b01 read, 2'b10 write, 2'b00 and 2'b11 no request.
- core_addr  in  ADDR_W*CORES  per-Core address.
- core_wr_data  in  REG_W*CORES  per-Core write data.
- core_rd_data  out  REG_W  read data, broadcast to all Cores; valid when that Core's core_ready is high.
- core_ready  out  CORES  one-hot, single-cycle completion pulse.
- mem_enable  out  2  to memory, same encoding as core_enable.
- mem_addr  out  ADDR_W  to memory.
- mem_wr_data  out  REG_W  to memory.
- mem_rd_data  in  REG_W  from memory.
- mem_ready  in  1  memory completion, sampled only in BUSY.
- grant_id  out  $clog2(CORES)  index of the current or last granted Core.
- busy  out  1  high in BUSY and RELEASE.
- timeout_err  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Round-robin pointer last=CORES-1, so Core 0 has first priority.
  - Wait counter 0.
  - Reset mid-transaction abandons the access; no core_ready is issued.
- A Core has a valid request when core_enable[i] is 2'b01 or 2'b10.
- Core contract: a Core holds enable/addr/wr_data stable until its core_ready pulse, then drops enable on the next edge.
- IDLE:
  - If any valid request exists, grant the first i scanning last+1, last+2, … modulo CORES.
  - Register grant_id=i and last=i.
  - Latch the Core's enable into mem_enable, and its addr and wr_data into mem_addr and mem_wr_data.
  - Go to BUSY.
  - With no valid request, remain in IDLE with mem_enable=0.
- BUSY:
  - mem_enable, mem_addr and mem_wr_data are held stable from the latched values. Later changes on the Core inputs are ignored.
  - Wait counter increments every cycle.
  - On the edge that samples mem_ready=1:
    - core_ready[grant_id]<=1.
    - core_rd_data<=mem_rd_data for reads; holds its previous value for writes.
    - mem_enable<=0 and the counter is cleared.
    - Go to RELEASE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with mem_ready still 0:
    - Same actions as completion, except core_rd_data<=0 and timeout_err<=1.
- RELEASE:
  - One cycle. core_ready<=0, then go to IDLE.
  - This guarantees the completed Core's stale enable is never re-granted.
- Latency: request sampled in IDLE at edge E.
  - mem_enable is valid after E.
  - With mem_ready=1 on the first BUSY cycle, core_ready is high after E+1.
  - Minimum repeat period is 3 cycles per access.
- mem_ready outside BUSY is ignored.
- Fairness:
  - With all Cores requesting continuously, grants rotate 0,1,…,CORES-1,0.
  - No Core waits more than CORES-1 grants.
- core_ready is never multi-hot and never high for more than one cycle.

Test Plan:
- Reset, then Core 1 reads addr 0x12 with mem_rd_data=0xA5 and mem_ready returned on the second BUSY cycle -> mem_enable=01 and mem_addr=0x12 for 2 cycles, then core_ready=4'b0010 for one cycle with core_rd_data=0xA5, grant_id=1.
- Core 2 writes 0x3C to addr 0x40 -> mem_enable=10, mem_wr_data=0x3C, mem_addr=0x40 until mem_ready; core_ready[2] pulses; core_rd_data unchanged.
- All 4 Cores request from reset, each dropping enable after its ready -> grant order 0,1,2,3. Then Core 0 re-requests while Core 3 is served -> Core 0 is granted next.
- Core 0 and Core 3 request on the same cycle with last=0 -> Core 3 granted first, Core 0 second. Both receive correct read data and a one-cycle ready.
- TIMEOUT=4, mem_ready held 0 -> after 4 BUSY cycles core_ready pulses, core_rd_data=0, timeout_err=1 and stays 1 across later accesses until reset.
- reset asserted mid-BUSY, with mem_ready asserted 1 cycle later -> all outputs immediately 0. No core_ready, and the post-reset first grant goes to Core 0 when all Cores request.
